// File: rtl/product_pkg.sv
`default_nettype none
// ============================================================================
// Module   : product_pkg
// Purpose  : Shared types and helpers for the sequential shift-add product
//            register (product_register_seq, product_step_alu).
// Contents : prod_state_t  - control state encoding (IDLE, RUN, DONE)
//            count_width() - iteration counter width for a given word length
// Revision : 1.0  initial release
// ============================================================================
package product_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } prod_state_t;

  // Counter must hold 0..W-1; never let it collapse to zero bits.
  function automatic int count_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/product_step_alu.sv
`default_nettype none
// ============================================================================
// Module   : product_step_alu
// Purpose  : One radix-2 shift-add step. Conditionally adds M to A (or
//            subtracts it on the last step in signed mode), then shifts
//            {A, Q} right by one bit.
// Config   : PRODUCT_REG_SIGNED_EN - two's complement operation
// Ports    : a      in  W+1  partial product high part
//            q      in  W    multiplier / low product bits
//            m      in  W+1  extended multiplicand
//            last   in  1    final iteration flag
//            a_next out W+1  A after step
//            q_next out W    Q after step
// Revision : 1.0  initial release
// ============================================================================
module product_step_alu #(
  parameter int WORD_LENGTH = 8
) (
  input  logic [WORD_LENGTH:0]   a,
  input  logic [WORD_LENGTH-1:0] q,
  input  logic [WORD_LENGTH:0]   m,
  input  logic                   last,
  output logic [WORD_LENGTH:0]   a_next,
  output logic [WORD_LENGTH-1:0] q_next
);

  logic [WORD_LENGTH:0] sum;
  logic                 fill;

`ifdef PRODUCT_REG_SIGNED_EN
  // The multiplier's sign bit carries negative weight, so the final
  // partial product is subtracted rather than added.
  always_comb begin
    sum = a;
    if (q[0]) begin
      sum = last ? (a - m) : (a + m);
    end
  end
  assign fill = sum[WORD_LENGTH];
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    sum = a;
    if (q[0]) begin
      sum = a + m;
    end
  end
  // Carry already sits in sum[W]; after the shift A's top bit is empty.
  assign fill = 1'b0;
`endif

  assign a_next = {fill, sum[WORD_LENGTH:1]};
  assign q_next = {sum[0], q[WORD_LENGTH-1:1]};

endmodule
`default_nettype wire

// File: rtl/product_register_seq.sv
`default_nettype none
// ============================================================================
// Module   : product_register_seq
// Purpose  : Sequential shift-add multiplier product register with built-in
//            iteration control. One operand pair per start, WORD_LENGTH
//            steps, held 2*WORD_LENGTH-bit product and a done pulse.
// Config   : PRODUCT_REG_SIGNED_EN - two's complement operands
// Ports    : clk           in  1   rising-edge clock
//            reset         in  1   synchronous active-high reset
//            clear         in  1   synchronous abort to IDLE
//            start         in  1   begin multiply (IDLE/DONE only)
//            multiplicand  in  W   operand M
//            multiplier    in  W   operand Q
//            product       out 2W  {A[W-1:0], Q}
//            busy          out 1   high in RUN
//            done          out 1   one-cycle pulse in DONE
//            product_valid out 1   result valid until next start/clear/reset
// Revision : 1.0  initial release
// ============================================================================
module product_register_seq
  import product_pkg::*;
#(
  parameter int WORD_LENGTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       start,
  input  logic [WORD_LENGTH-1:0]     multiplicand,
  input  logic [WORD_LENGTH-1:0]     multiplier,
  output logic [2*WORD_LENGTH-1:0]   product,
  output logic                       busy,
  output logic                       done,
  output logic                       product_valid
);

  localparam int CW = count_width(WORD_LENGTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WORD_LENGTH - 1);

  prod_state_t            state, state_next;
  logic [WORD_LENGTH:0]   a, a_d, a_step;
  logic [WORD_LENGTH-1:0] q, q_d, q_step;
  logic [WORD_LENGTH:0]   m, m_d, m_ext;
  logic [CW-1:0]          count, count_d;
  logic                   valid, valid_d;
  logic                   last;

`ifdef PRODUCT_REG_SIGNED_EN
  assign m_ext = {multiplicand[WORD_LENGTH-1], multiplicand};
`else
  assign m_ext = {1'b0, multiplicand};
`endif

  assign last = (count == LAST_COUNT);

  product_step_alu #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_step (
    .a      (a),
    .q      (q),
    .m      (m),
    .last   (last),
    .a_next (a_step),
    .q_next (q_step)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= IDLE;
      a     <= '0;
      q     <= '0;
      m     <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      a     <= a_d;
      q     <= q_d;
      m     <= m_d;
      count <= count_d;
      valid <= valid_d;
    end
  end

  always_comb begin
    state_next = state;
    a_d        = a;
    q_d        = q;
    m_d        = m;
    count_d    = count;
    valid_d    = valid;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          a_d        = '0;
          q_d        = multiplier;
          m_d        = m_ext;
          count_d    = '0;
          valid_d    = 1'b0;
          state_next = RUN;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        a_d     = a_step;
        q_d     = q_step;
        count_d = count + 1'b1;
        if (last) begin
          valid_d    = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign product       = {a[WORD_LENGTH-1:0], q};
  assign busy          = (state == RUN);
  assign done          = (state == DONE);
  assign product_valid = valid;

endmodule
`default_nettype wire
